multi_channel_capture: RTL and testbench

Triggered capture block for NCH digitizer channels that share one sample strobe. Each channel keeps its own circular sample buffer. On an accepted trigger, the block freezes a window of PRE pre-trigger and POST post-trigger samples per channel. It then streams that window out channel by channel over a valid/ready interface. It sits between the per-channel LVDS deserializers and the readout/event builder, and generalises the single-channel buffer/state-machine/address-control path to N channels, a programmable pre-trigger window and flow-controlled readout.

---
 rtl/multi_channel_capture.sv | 193 +++++++++++++++++++
 tb/tb_multi_channel_capture.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/multi_channel_capture.sv
// Triggered multi-channel capture: per-channel circular buffers, a programmable pre/post window
// frozen on trigger, and channel-by-channel valid/ready readout through a 2-entry skid.
module multi_channel_capture #(
  parameter int unsigned NCH   = 4,
  parameter int unsigned WIDTH = 12,
  parameter int unsigned AW    = 11,
  parameter int unsigned CW    = 2
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 ENABLE,
  input  logic [NCH*WIDTH-1:0] DIN,
  input  logic                 DVALID,
  input  logic                 TRIGGER,
  input  logic [AW-1:0]        PRE,
  input  logic [AW-1:0]        POST,
  output logic [WIDTH-1:0]     DOUT,
  output logic [CW-1:0]        DOUT_CH,
  output logic                 DOUT_VALID,
  output logic                 DOUT_LAST,
  input  logic                 DOUT_READY,
  output logic                 BUSY
);

  localparam int unsigned Depth = 1 << AW;
  localparam logic [AW:0] DepthW = (AW+1)'(Depth);

  typedef enum logic [1:0] {StIdle, StArmed, StPostTrig, StReadout} state_e;

  state_e            state_q;
  logic [AW-1:0]     pre_q, post_q, wr_ptr_q, post_cnt_q;
  logic [AW:0]       fill_q;
  logic [CW-1:0]     rd_ch_q;
  logic [AW:0]       rd_idx_q;
  logic              issue_done_q;
  logic              ram_vld_q, ram_last_q;
  logic [CW-1:0]     ram_ch_q;
  logic [WIDTH-1:0]  ram_data_q;
  logic              sk_vld_q, sk_last_q;
  logic [CW-1:0]     sk_ch_q;
  logic [WIDTH-1:0]  sk_data_q;

  logic [WIDTH-1:0]  mem [NCH][Depth];

  logic [AW:0]       win_sum, win_len;
  logic [AW-1:0]     rd_addr;
  logic [1:0]        held;
  logic              accept, wr_en, rd_en, pop, last_word;

  always_comb begin
    win_sum   = {1'b0, pre_q} + {1'b0, post_q};
    win_len   = (win_sum > DepthW) ? DepthW : win_sum;
    accept    = (state_q == StArmed) && TRIGGER && (fill_q >= {1'b0, pre_q});
    // With POST=0 the acceptance-cycle sample must stay outside the window, so it is not written.
    wr_en     = DVALID && (((state_q == StArmed) && !(accept && (post_q == '0))) ||
                           (state_q == StPostTrig));
    pop       = DOUT_VALID && DOUT_READY;
    rd_addr   = wr_ptr_q - win_len[AW-1:0] + rd_idx_q[AW-1:0];
    last_word = (rd_ch_q == CW'(NCH-1)) && (rd_idx_q == win_len - 1'b1);
    // Words in the output stage, skid and RAM pipe after this cycle's pop; never exceeds 2.
    held      = 2'(DOUT_VALID) + 2'(sk_vld_q) + 2'(ram_vld_q) - 2'(pop);
    rd_en     = (state_q == StReadout) && !issue_done_q && (win_len != '0) && (held < 2'd2);
  end

  always_ff @(posedge CLK) begin
    if (wr_en) begin
      for (int k = 0; k < NCH; k++) begin
        mem[k][wr_ptr_q] <= DIN[k*WIDTH +: WIDTH];
      end
    end
    if (rd_en) begin
      ram_data_q <= mem[rd_ch_q][rd_addr];
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= StIdle;
      pre_q        <= '0;
      post_q       <= '0;
      wr_ptr_q     <= '0;
      post_cnt_q   <= '0;
      fill_q       <= '0;
      rd_ch_q      <= '0;
      rd_idx_q     <= '0;
      issue_done_q <= 1'b0;
      ram_vld_q    <= 1'b0;
      ram_last_q   <= 1'b0;
      ram_ch_q     <= '0;
      sk_vld_q     <= 1'b0;
      sk_last_q    <= 1'b0;
      sk_ch_q      <= '0;
      sk_data_q    <= '0;
      DOUT         <= '0;
      DOUT_CH      <= '0;
      DOUT_VALID   <= 1'b0;
      DOUT_LAST    <= 1'b0;
      BUSY         <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (ENABLE) begin
            state_q      <= StArmed;
            pre_q        <= PRE;
            post_q       <= POST;
            wr_ptr_q     <= '0;
            fill_q       <= '0;
            post_cnt_q   <= '0;
            rd_ch_q      <= '0;
            rd_idx_q     <= '0;
            issue_done_q <= 1'b0;
            BUSY         <= 1'b1;
          end
        end
        StArmed: begin
          if (accept) begin
            post_cnt_q <= DVALID ? AW'(1) : '0;
            if (post_q == '0 || (DVALID && post_q == AW'(1))) begin
              state_q <= StReadout;
            end else begin
              state_q <= StPostTrig;
            end
          end
        end
        StPostTrig: begin
          if (DVALID) begin
            post_cnt_q <= post_cnt_q + 1'b1;
            if (post_cnt_q + 1'b1 == post_q) begin
              state_q <= StReadout;
            end
          end
        end
        StReadout: begin
          if (win_len == '0 || (pop && DOUT_LAST)) begin
            state_q <= StIdle;
            BUSY    <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase

      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
        if (fill_q != DepthW) begin
          fill_q <= fill_q + 1'b1;
        end
      end

      if (rd_en) begin
        if (last_word) begin
          issue_done_q <= 1'b1;
        end
        if (rd_idx_q == win_len - 1'b1) begin
          rd_idx_q <= '0;
          rd_ch_q  <= rd_ch_q + 1'b1;
        end else begin
          rd_idx_q <= rd_idx_q + 1'b1;
        end
      end
      ram_vld_q  <= rd_en;
      ram_ch_q   <= rd_ch_q;
      ram_last_q <= rd_en && last_word;

      // Output register refills from the skid first, then straight from the RAM pipe.
      if (pop || !DOUT_VALID) begin
        if (sk_vld_q) begin
          DOUT       <= sk_data_q;
          DOUT_CH    <= sk_ch_q;
          DOUT_LAST  <= sk_last_q;
          DOUT_VALID <= 1'b1;
          sk_vld_q   <= ram_vld_q;
          sk_data_q  <= ram_data_q;
          sk_ch_q    <= ram_ch_q;
          sk_last_q  <= ram_last_q;
        end else if (ram_vld_q) begin
          DOUT       <= ram_data_q;
          DOUT_CH    <= ram_ch_q;
          DOUT_LAST  <= ram_last_q;
          DOUT_VALID <= 1'b1;
        end else begin
          DOUT_VALID <= 1'b0;
          DOUT_LAST  <= 1'b0;
        end
      end else if (ram_vld_q) begin
        sk_vld_q  <= 1'b1;
        sk_data_q <= ram_data_q;
        sk_ch_q   <= ram_ch_q;
        sk_last_q <= ram_last_q;
      end
    end
  end

endmodule

// File: tb/tb_multi_channel_capture.sv
// Bench for multi_channel_capture: table of capture scenarios with a word scoreboard,
// plus a hand-written reset-during-readout sequence.
module tb_multi_channel_capture;

  localparam int NCH   = 4;
  localparam int WIDTH = 12;
  localparam int AW    = 4;
  localparam int CW    = 2;

  logic                 clk = 1'b0;
  logic                 RESET = 1'b1;
  logic                 ENABLE = 1'b0;
  logic [NCH*WIDTH-1:0] DIN = '0;
  logic                 DVALID = 1'b0;
  logic                 TRIGGER = 1'b0;
  logic [AW-1:0]        PRE = '0;
  logic [AW-1:0]        POST = '0;
  logic [WIDTH-1:0]     DOUT;
  logic [CW-1:0]        DOUT_CH;
  logic                 DOUT_VALID;
  logic                 DOUT_LAST;
  logic                 DOUT_READY = 1'b1;
  logic                 BUSY;

  always #5 clk = ~clk;

  multi_channel_capture #(.NCH(NCH), .WIDTH(WIDTH), .AW(AW), .CW(CW)) dut (
    .CLK(clk), .RESET(RESET), .ENABLE(ENABLE), .DIN(DIN), .DVALID(DVALID), .TRIGGER(TRIGGER),
    .PRE(PRE), .POST(POST), .DOUT(DOUT), .DOUT_CH(DOUT_CH), .DOUT_VALID(DOUT_VALID),
    .DOUT_LAST(DOUT_LAST), .DOUT_READY(DOUT_READY), .BUSY(BUSY)
  );

  typedef struct {
    int pre; int post; int trig_a; int trig_b; bit rnd;
    int exp_first; int exp_len;
  } vec_t;

  typedef struct {
    logic [WIDTH-1:0] d;
    logic [CW-1:0]    ch;
    logic             last;
  } word_t;

  word_t exp_q[$];
  word_t exp_w, held_w;
  int    n_vec = 0, n_err = 0;
  int    cyc = 0, hs = 0, first_hs = 0, last_hs = 0;
  bit    stall = 1'b0, rnd_mode = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: pops one expected word per handshake; checks stability across stalls.
  always @(negedge clk) begin
    cyc++;
    if (RESET) begin
      stall = 1'b0;
    end else begin
      if (stall) begin
        check("hold_valid", 32'(DOUT_VALID), 32'd1);
        check("hold_word", {DOUT, DOUT_CH, DOUT_LAST}, {held_w.d, held_w.ch, held_w.last});
      end
      stall = DOUT_VALID && !DOUT_READY;
      if (stall) held_w = '{DOUT, DOUT_CH, DOUT_LAST};
      if (DOUT_VALID && DOUT_READY) begin
        if (exp_q.size() == 0) begin
          check("extra_word", 32'd1, 32'd0);
        end else begin
          exp_w = exp_q.pop_front();
          check("word", {DOUT, DOUT_CH, DOUT_LAST}, {exp_w.d, exp_w.ch, exp_w.last});
        end
        if (hs == 0) first_hs = cyc;
        last_hs = cyc;
        hs++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    DOUT_READY = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic arm(input int pre, input int post);
    PRE    = pre[AW-1:0];
    POST   = post[AW-1:0];
    ENABLE = 1'b1;
    step();
    ENABLE = 1'b0;
    check("busy_after_arm", 32'(BUSY), 32'd1);
  endtask

  task automatic push_expected(input int first, input int len);
    for (int k = 0; k < NCH; k++) begin
      for (int i = 0; i < len; i++) begin
        exp_q.push_back('{WIDTH'(k * 256 + first + i), CW'(k), (k == NCH - 1) && (i == len - 1)});
      end
    end
  endtask

  task automatic drive_samples(input int last_n, input int trig_a, input int trig_b);
    for (int n = 0; n <= last_n; n++) begin
      for (int k = 0; k < NCH; k++) DIN[k*WIDTH +: WIDTH] = WIDTH'(k * 256 + n);
      DVALID  = 1'b1;
      TRIGGER = (n == trig_a) || (n == trig_b);
      step();
      if (n == trig_a) check("busy_after_ignored_trig", 32'(BUSY), 32'd1);
    end
    DVALID  = 1'b0;
    TRIGGER = 1'b0;
  endtask

  task automatic run_case(input vec_t v);
    rnd_mode = v.rnd;
    hs       = 0;
    arm(v.pre, v.post);
    push_expected(v.exp_first, v.exp_len);
    drive_samples(v.trig_b + v.post + 2, v.trig_a, v.trig_b);
    for (int c = 0; c < 400 && (BUSY || exp_q.size() != 0); c++) step();
    check("drained", 32'(exp_q.size()), 32'd0);
    check("busy_idle", 32'(BUSY), 32'd0);
    check("word_count", 32'(hs), 32'(NCH * v.exp_len));
    if (!v.rnd && v.exp_len > 0) check("burst_span", 32'(last_hs - first_hs), 32'(NCH * v.exp_len - 1));
    exp_q.delete();
    rnd_mode = 1'b0;
  endtask

  vec_t vecs[7];

  initial begin
    // pre, post, ignored trigger, accepted trigger, random ready, first sample, window length
    vecs[0] = '{3, 5, -1, 10, 1'b0, 7, 8};    // basic window
    vecs[1] = '{3, 5, -1, 20, 1'b0, 17, 8};   // wrap-around
    vecs[2] = '{3, 5, 1, 6, 1'b0, 3, 8};      // early trigger ignored
    vecs[3] = '{12, 8, -1, 30, 1'b0, 22, 16}; // window saturates at depth
    vecs[4] = '{2, 0, -1, 5, 1'b0, 3, 2};     // POST=0
    vecs[5] = '{0, 0, -1, 0, 1'b0, 0, 0};     // empty window
    vecs[6] = '{3, 5, -1, 10, 1'b1, 7, 8};    // backpressure

    RESET = 1'b1;
    repeat (3) step();
    RESET = 1'b0;
    check("rst_dout", 32'(DOUT), 32'd0);
    check("rst_dout_ch", 32'(DOUT_CH), 32'd0);
    check("rst_valid", 32'(DOUT_VALID), 32'd0);
    check("rst_last", 32'(DOUT_LAST), 32'd0);
    check("rst_busy", 32'(BUSY), 32'd0);

    for (int i = 0; i < 7; i++) run_case(vecs[i]);

    // Reset while the 5th readout word is presented.
    hs = 0;
    arm(3, 5);
    push_expected(7, 8);
    drive_samples(17, -1, 10);
    for (int c = 0; c < 100 && !(hs == 4 && DOUT_VALID); c++) step();
    check("reached_word5", 32'(hs == 4 && DOUT_VALID), 32'd1);
    RESET      = 1'b1;
    DOUT_READY = 1'b0;
    step();
    RESET = 1'b0;
    check("midrst_dout", 32'(DOUT), 32'd0);
    check("midrst_dout_ch", 32'(DOUT_CH), 32'd0);
    check("midrst_valid", 32'(DOUT_VALID), 32'd0);
    check("midrst_last", 32'(DOUT_LAST), 32'd0);
    check("midrst_busy", 32'(BUSY), 32'd0);
    exp_q.delete();
    step();
    run_case(vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
